// File: rtl/uart_dword_packer_pkg.sv
// uart_dword_packer_pkg
//   Shared definitions for the UART dword packer: header field positions,
//   sequencer state encoding and small header field accessors.
//   No ports (package).

package uart_dword_packer_pkg;

    // Header word layout: [7:0] command, [15:8] payload count, [31:16] opaque.
    localparam int HDR_CMD_LSB = 0;
    localparam int HDR_CMD_W   = 8;
    localparam int HDR_LEN_LSB = 8;
    localparam int HDR_LEN_W   = 8;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_SETTLE  = 2'd1,
        S_PAYLOAD = 2'd2
    } seq_state_t;

    function automatic logic [HDR_CMD_W-1:0] hdr_cmd(input logic [31:0] w);
        return w[HDR_CMD_LSB +: HDR_CMD_W];
    endfunction

    function automatic logic [HDR_LEN_W-1:0] hdr_len(input logic [31:0] w);
        return w[HDR_LEN_LSB +: HDR_LEN_W];
    endfunction

endpackage

// File: rtl/dword_fifo.sv
// dword_fifo
//   Synchronous FIFO with a registered read-data port that always holds the
//   current head entry (valid whenever empty==0), so a consumer can pop and
//   use rd_data in the same cycle.
// Ports:
//   clk_in     system clock, rising edge
//   reset      asynchronous, active-high reset
//   push       write push_data (accepted if not full, or if popping this cycle)
//   push_data  word to write
//   pop        remove head entry (ignored when empty)
//   full       DEPTH entries stored
//   empty      no entries stored
//   rd_data    head entry (registered)

module dword_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16
) (
    input  logic             clk_in,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] rd_data
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [AW:0]      rd_ptr_nxt;
    logic             push_ok;
    logic             pop_ok;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop_ok  = pop && !empty;
    // A full FIFO still takes a word when the head leaves in the same cycle.
    assign push_ok = push && (!full || pop_ok);

    assign rd_ptr_nxt = pop_ok ? rd_ptr + 1'b1 : rd_ptr;

    always_ff @(posedge clk_in) begin
        if (push_ok) begin
            mem[wr_ptr[AW-1:0]] <= push_data;
        end
    end

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            rd_data <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            rd_ptr <= rd_ptr_nxt;
            // The new head is the word being written when the FIFO is (or is
            // about to become) empty; otherwise it is already in memory.
            if (push_ok && (wr_ptr[AW-1:0] == rd_ptr_nxt[AW-1:0])) begin
                rd_data <= push_data;
            end else begin
                rd_data <= mem[rd_ptr_nxt[AW-1:0]];
            end
        end
    end

endmodule

// File: rtl/uart_dword_packer.sv
// uart_dword_packer
//   Packs the host UART byte stream little-endian into 32-bit words, queues
//   them and replays them to dword_interface as single-cycle wr strobes paced
//   by the command framing in each header word.
// Ports:
//   clk_in        system clock, rising edge
//   reset         asynchronous, active-high reset
//   rx_data       received byte
//   rx_valid      one-cycle strobe qualifying rx_data
//   dwi_busy      busy from dword_interface (gates header strobes only)
//   data_from_PC  word presented to dword_interface, held between strobes
//   wr            one-cycle write strobe
//   overflow      sticky: a word was dropped because the FIFO was full
//   resync        one-cycle pulse when a partial word is discarded on timeout
//   frame_active  high from a header strobe until the frame's last payload strobe
//
// Sequencer states:
//   state      | meaning
//   S_IDLE     | waiting for a queued header and dwi_busy low
//   S_SETTLE   | header strobed, letting dwi_busy settle for SETTLE_CYCLES
//   S_PAYLOAD  | streaming payload words, one strobe per non-empty slot, busy ignored

module uart_dword_packer
    import uart_dword_packer_pkg::*;
#(
    parameter int DEPTH          = 16,
    parameter int TIMEOUT_CYCLES = 100000,
    parameter int SETTLE_CYCLES  = 2
) (
    input  logic        clk_in,
    input  logic        reset,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    input  logic        dwi_busy,
    output logic [31:0] data_from_PC,
    output logic        wr,
    output logic        overflow,
    output logic        resync,
    output logic        frame_active
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    // ---------------- byte assembler ----------------
    logic [1:0]    byte_idx;
    logic [23:0]   word_lo;
    logic [TW-1:0] tmo_cnt;
    logic          push;
    logic [31:0]   push_word;

    assign push      = rx_valid && (byte_idx == 2'd3);
    assign push_word = {rx_data, word_lo};

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            byte_idx <= 2'd0;
            word_lo  <= '0;
            tmo_cnt  <= '0;
            resync   <= 1'b0;
        end else begin
            resync <= 1'b0;
            if (rx_valid) begin
                // A byte arriving in the timeout cycle takes priority.
                case (byte_idx)
                    2'd0:    word_lo[7:0]   <= rx_data;
                    2'd1:    word_lo[15:8]  <= rx_data;
                    2'd2:    word_lo[23:16] <= rx_data;
                    default: ;
                endcase
                byte_idx <= byte_idx + 2'd1;
                tmo_cnt  <= TW'(TIMEOUT_CYCLES - 1);
            end else if (byte_idx != 2'd0) begin
                if (tmo_cnt == '0) begin
                    byte_idx <= 2'd0;
                    resync   <= 1'b1;
                end else begin
                    tmo_cnt <= tmo_cnt - 1'b1;
                end
            end
        end
    end

    // ---------------- word FIFO ----------------
    logic        fifo_full;
    logic        fifo_empty;
    logic [31:0] fifo_head;
    logic        pop;

    dword_fifo #(
        .WIDTH (32),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_in    (clk_in),
        .reset     (reset),
        .push      (push),
        .push_data (push_word),
        .pop       (pop),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .rd_data   (fifo_head)
    );

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            overflow <= 1'b0;
        end else if (push && fifo_full && !pop) begin
            overflow <= 1'b1;
        end
    end

    // ---------------- strobe sequencer ----------------
    seq_state_t          state;
    logic [HDR_LEN_W-1:0] remaining;
    logic [SW-1:0]        settle_cnt;

    // Gating on !wr enforces the 2-cycle minimum strobe cadence, including the
    // step from a frame's last payload strobe straight into the next header.
    assign pop = !wr && !fifo_empty &&
                 (((state == S_IDLE) && !dwi_busy) || (state == S_PAYLOAD));

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            state        <= S_IDLE;
            remaining    <= '0;
            settle_cnt   <= '0;
            wr           <= 1'b0;
            data_from_PC <= '0;
            frame_active <= 1'b0;
        end else begin
            wr <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (pop) begin
                        data_from_PC <= fifo_head;
                        wr           <= 1'b1;
                        remaining    <= hdr_len(fifo_head);
                        frame_active <= 1'b1;
                        settle_cnt   <= SW'(SETTLE_CYCLES - 1);
                        state        <= S_SETTLE;
                    end
                end
                S_SETTLE: begin
                    if (settle_cnt == '0) begin
                        if (remaining != '0) begin
                            state <= S_PAYLOAD;
                        end else begin
                            frame_active <= 1'b0;
                            state        <= S_IDLE;
                        end
                    end else begin
                        settle_cnt <= settle_cnt - 1'b1;
                    end
                end
                S_PAYLOAD: begin
                    if (pop) begin
                        data_from_PC <= fifo_head;
                        wr           <= 1'b1;
                        remaining    <= remaining - 1'b1;
                        if (remaining == HDR_LEN_W'(1)) begin
                            frame_active <= 1'b0;
                            state        <= S_IDLE;
                        end
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_dword_packer.sv
// tb_uart_dword_packer
//   Directed self-checking bench for uart_dword_packer: table of single header
//   words plus hand-written sequences for framing, busy gating, timeout,
//   overflow and reset mid-stream.

module tb_uart_dword_packer;

    localparam int DEPTH   = 16;
    localparam int TMO     = 40;
    localparam int SETTLE  = 2;

    logic        clk_in;
    logic        reset;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        dwi_busy;
    logic [31:0] data_from_PC;
    logic        wr;
    logic        overflow;
    logic        resync;
    logic        frame_active;

    uart_dword_packer #(
        .DEPTH          (DEPTH),
        .TIMEOUT_CYCLES (TMO),
        .SETTLE_CYCLES  (SETTLE)
    ) dut (
        .clk_in       (clk_in),
        .reset        (reset),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .dwi_busy     (dwi_busy),
        .data_from_PC (data_from_PC),
        .wr           (wr),
        .overflow     (overflow),
        .resync       (resync),
        .frame_active (frame_active)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    int checks = 0;
    int errors = 0;

    // ---------------- monitor (samples on falling edge) ----------------
    logic [31:0] got_q [$];
    logic        fa_q  [$];
    int          cyc_q [$];
    int          cyc = 0;
    int          wr_cyc = 0;
    int          fa_fall_cyc = 0;
    int          back2back = 0;
    int          data_glitch = 0;
    int          resync_cnt = 0;
    logic        prev_wr = 1'b0;
    logic        prev_fa = 1'b0;
    logic [31:0] prev_data = 32'h0;

    always @(negedge clk_in) begin
        cyc = cyc + 1;
        if (reset) begin
            prev_wr   = 1'b0;
            prev_fa   = 1'b0;
            prev_data = 32'h0;
        end else begin
            if (wr) begin
                got_q.push_back(data_from_PC);
                fa_q.push_back(frame_active);
                cyc_q.push_back(cyc);
                wr_cyc = cyc;
            end
            if (wr && prev_wr) back2back = back2back + 1;
            if (!wr && (data_from_PC !== prev_data)) data_glitch = data_glitch + 1;
            if (prev_fa && !frame_active) fa_fall_cyc = cyc;
            if (resync) resync_cnt = resync_cnt + 1;
            prev_wr   = wr;
            prev_fa   = frame_active;
            prev_data = data_from_PC;
        end
    end

    // ---------------- helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk_in);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk_in);
        #1;
        rx_valid = 1'b0;
        idle(gap);
    endtask

    task automatic send_word(input logic [31:0] w, input int gap);
        send_byte(w[7:0],   gap);
        send_byte(w[15:8],  gap);
        send_byte(w[23:16], gap);
        send_byte(w[31:24], gap);
    endtask

    task automatic clear_log();
        got_q.delete();
        fa_q.delete();
        cyc_q.delete();
    endtask

    task automatic wait_strobes(input int n, input int budget);
        int k;
        k = 0;
        while ((got_q.size() < n) && (k < budget)) begin
            @(posedge clk_in);
            #1;
            k++;
        end
        if (got_q.size() < n) begin
            checks = checks + 1;
            errors = errors + 1;
            $display("FAIL wait_strobes actual=%0d required=%0d", got_q.size(), n);
        end
    endtask

    function automatic logic [31:0] q_at(input int i);
        if (i < got_q.size()) return got_q[i];
        return 32'hDEAD_DEAD;
    endfunction

    // ---------------- vectors ----------------
    typedef struct packed {
        logic [7:0]  b0;
        logic [7:0]  b1;
        logic [7:0]  b2;
        logic [7:0]  b3;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [4];

    initial begin
        int n0;
        int rs0;
        logic [31:0] pw;

        vecs[0] = '{b0: 8'h9F, b1: 8'h00, b2: 8'h00, b3: 8'h00, exp: 32'h0000_009F};
        vecs[1] = '{b0: 8'h06, b1: 8'h00, b2: 8'h34, b3: 8'h12, exp: 32'h1234_0006};
        vecs[2] = '{b0: 8'hC7, b1: 8'h00, b2: 8'hEF, b3: 8'hBE, exp: 32'hBEEF_00C7};
        vecs[3] = '{b0: 8'h05, b1: 8'h00, b2: 8'hAA, b3: 8'h55, exp: 32'h55AA_0005};

        reset    = 1'b1;
        rx_data  = 8'h00;
        rx_valid = 1'b0;
        dwi_busy = 1'b0;
        repeat (3) @(posedge clk_in);
        @(negedge clk_in);
        chk("rst_data", data_from_PC, 32'h0);
        chk("rst_wr", {31'h0, wr}, 32'h0);
        chk("rst_ovf", {31'h0, overflow}, 32'h0);
        chk("rst_resync", {31'h0, resync}, 32'h0);
        chk("rst_fa", {31'h0, frame_active}, 32'h0);
        @(posedge clk_in);
        #1;
        reset = 1'b0;
        idle(2);

        // Single header words with N=0: one strobe each, frame closes after settle.
        for (int i = 0; i < 4; i++) begin
            clear_log();
            send_byte(vecs[i].b0, 0);
            send_byte(vecs[i].b1, 0);
            send_byte(vecs[i].b2, 0);
            send_byte(vecs[i].b3, 0);
            wait_strobes(1, 20);
            idle(10);
            chk("vec_count", got_q.size(), 1);
            chk("vec_data", q_at(0), vecs[i].exp);
            chk("vec_fa_at_wr", (fa_q.size() > 0) ? {31'h0, fa_q[0]} : 32'hX, 32'h1);
            chk("vec_fa_fall", fa_fall_cyc - wr_cyc, SETTLE);
        end

        // Header + one payload word, busy raised at the first strobe.
        clear_log();
        fork
            begin
                send_word(32'h0000_0161, 0);
                send_word(32'h0000_004F, 0);
            end
            begin
                for (int k = 0; k < 40; k++) begin
                    @(negedge clk_in);
                    if (got_q.size() >= 1) break;
                end
                dwi_busy = 1'b1;
            end
        join
        wait_strobes(2, 40);
        idle(10);
        chk("hp_count", got_q.size(), 2);
        chk("hp_hdr", q_at(0), 32'h0000_0161);
        chk("hp_pay", q_at(1), 32'h0000_004F);
        chk("hp_gap", (cyc_q.size() >= 2) ? ((cyc_q[1] - cyc_q[0]) >= 2) : 32'h0, 32'h1);
        chk("hp_fa_end", {31'h0, frame_active}, 32'h0);
        dwi_busy = 1'b0;
        idle(4);

        // Header gating by busy.
        clear_log();
        dwi_busy = 1'b1;
        send_word(32'h0000_0006, 0);
        idle(20);
        chk("gate_held", got_q.size(), 0);
        dwi_busy = 1'b0;
        n0 = cyc;
        wait_strobes(1, 10);
        chk("gate_lat", (got_q.size() > 0) ? ((wr_cyc - n0) <= 2) : 32'h0, 32'h1);
        chk("gate_data", q_at(0), 32'h0000_0006);
        idle(6);

        // Page program: header + 65 payload words at one byte per four cycles.
        clear_log();
        send_word(32'h0001_4102, 3);
        for (int i = 0; i < 65; i++) begin
            if (i == 0)       pw = 32'h00AB_CDEF;
            else if (i == 64) pw = 32'h4040_4040;
            else              pw = 32'h1000_0000 + i;
            send_word(pw, 3);
        end
        wait_strobes(66, 200);
        idle(10);
        chk("pp_count", got_q.size(), 66);
        chk("pp_hdr", q_at(0), 32'h0001_4102);
        chk("pp_first", q_at(1), 32'h00AB_CDEF);
        chk("pp_mid", q_at(33), 32'h1000_0020);
        chk("pp_last", q_at(65), 32'h4040_4040);
        chk("pp_ovf", {31'h0, overflow}, 32'h0);
        chk("pp_fa_65", (fa_q.size() == 66) ? {31'h0, fa_q[64]} : 32'hX, 32'h1);
        chk("pp_fa_66", (fa_q.size() == 66) ? {31'h0, fa_q[65]} : 32'hX, 32'h0);

        // Timeout discards a partial word.
        clear_log();
        rs0 = resync_cnt;
        send_byte(8'hAA, 0);
        send_byte(8'hBB, 0);
        idle(TMO - 5);
        chk("tmo_early", resync_cnt - rs0, 0);
        idle(10);
        chk("tmo_resync", resync_cnt - rs0, 1);
        send_word(32'h0000_009F, 0);
        wait_strobes(1, 20);
        idle(10);
        chk("tmo_count", got_q.size(), 1);
        chk("tmo_data", q_at(0), 32'h0000_009F);

        // Overflow: DEPTH+1 headers while busy.
        clear_log();
        dwi_busy = 1'b1;
        for (int i = 0; i <= DEPTH; i++) begin
            send_word(32'h0000_0030 + i + (i << 16), 0);
        end
        idle(5);
        chk("ovf_set", {31'h0, overflow}, 32'h1);
        chk("ovf_none_out", got_q.size(), 0);
        idle(20);
        chk("ovf_sticky", {31'h0, overflow}, 32'h1);
        dwi_busy = 1'b0;
        wait_strobes(DEPTH, DEPTH * 4 + 40);
        idle(20);
        chk("ovf_count", got_q.size(), DEPTH);
        for (int i = 0; i < DEPTH; i++) begin
            chk("ovf_order", q_at(i), 32'h0000_0030 + i + (i << 16));
        end
        chk("ovf_still", {31'h0, overflow}, 32'h1);

        // Reset mid-stream.
        clear_log();
        dwi_busy = 1'b1;
        for (int i = 0; i < 6; i++) begin
            send_word(32'h0000_0050 + i, 0);
        end
        dwi_busy = 1'b0;
        wait_strobes(2, 20);
        reset = 1'b1;
        @(negedge clk_in);
        chk("mr_ovf", {31'h0, overflow}, 32'h0);
        chk("mr_wr", {31'h0, wr}, 32'h0);
        chk("mr_fa", {31'h0, frame_active}, 32'h0);
        idle(2);
        reset = 1'b0;
        clear_log();
        idle(30);
        chk("mr_quiet", got_q.size(), 0);
        chk("mr_ovf_after", {31'h0, overflow}, 32'h0);

        chk("cadence", back2back, 0);
        chk("data_hold", data_glitch, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
